// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single asynchronous-strobe RAM.
// Each access runs IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> FINISH -> IDLE.
module ram_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_r,
    output logic              ram_w,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES - 1);

    // Handshake: a port raises req and holds it; the arbiter samples req,
    // we, addr and wdata only in IDLE, and answers with a one-cycle ack in
    // FINISH. Dropping req after the grant does not cancel the access.

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic any_req;
    logic grant_sel;

    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        any_req   = p0_req | p1_req;
        grant_sel = 1'b0;
        if (p0_req && p1_req) begin
            grant_sel = ~last_grant_q;
        end else if (p1_req) begin
            grant_sel = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = SETUP;
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    we_d         = grant_sel ? p1_we    : p0_we;
                    addr_d       = grant_sel ? p1_addr  : p0_addr;
                    wdata_d      = grant_sel ? p1_wdata : p0_wdata;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 4'd0;
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FINISH;
                    cnt_d   = 4'd0;
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_d = ram_rdata;
                        end else begin
                            rdata0_d = ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Strobes and acks decode straight from the state register, so an
    // asynchronous reset drops them in the same cycle.
    always_comb begin
        ram_r       = (state_q == STROBE) && !we_q;
        ram_w       = (state_q == STROBE) &&  we_q;
        p0_ack      = (state_q == FINISH) && !grant_q;
        p1_ack      = (state_q == FINISH) &&  grant_q;
        busy        = (state_q != IDLE);
        ram_addr    = addr_q;
        ram_wdata   = wdata_q;
        p0_rdata    = rdata0_q;
        p1_rdata    = rdata1_q;
        dbg_state_o = state_q;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the RAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 Parameter STROBE_CYCLES, default 2, legal range 1..15, SHALL set the number of cycles ram_r or ram_w is held high.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 p0_req, p1_req  in  1  access request per port; the requester holds it until ack.
REQ-007 p0_we, p1_we  in  1  1 = write, 0 = read.
REQ-008 p0_addr, p1_addr  in  ADDR_W  access address.
REQ-009 p0_wdata, p1_wdata  in  DATA_W  write data.
REQ-010 p0_ack, p1_ack  out  1  single-cycle completion pulse.
REQ-011 p0_rdata, p1_rdata  out  DATA_W  read data, registered per port.
REQ-012 ram_addr  out  ADDR_W  address to the RAM.
REQ-013 ram_wdata  out  DATA_W  write data to the RAM.
REQ-014 ram_rdata  in  DATA_W  read data from the RAM.
REQ-015 ram_r, ram_w  out  1  RAM read and write strobes.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETUP, STROBE and FINISH.
REQ-018 In IDLE with any req high, the FSM SHALL grant one port, latch that port's we, addr and wdata, and go to SETUP.
- With no req high, the FSM stays in IDLE.
REQ-019 Arbitration SHALL be round-robin:
- With one req high, that port is granted.
- With both req high, the port not granted last is granted.
- last_grant resets to 1, so port 0 wins the first tie.
REQ-020 In SETUP the FSM SHALL drive ram_addr and ram_wdata from the latched values, with both strobes low, for exactly 1 cycle, then go to STROBE.
REQ-021 In STROBE the FSM SHALL hold ram_w (write) or ram_r (read) high for exactly STROBE_CYCLES cycles, using an internal counter, then go to FINISH.
REQ-022 For a read, ram_rdata SHALL be captured into the granted port's rdata register on the last STROBE cycle.
REQ-023 In FINISH both strobes SHALL be low, the granted port's ack SHALL be high for exactly 1 cycle, and the FSM SHALL then go to IDLE.
REQ-024 ram_r and ram_w SHALL never be high simultaneously, and SHALL never be high outside STROBE.
REQ-025 ram_addr and ram_wdata SHALL be stable from SETUP through FINISH, and SHALL hold their last value in IDLE.
REQ-026 Latency: a req sampled in IDLE at cycle N SHALL produce ack at cycle N+2+STROBE_CYCLES (N+4 by default).
- Back-to-back access period is 3+STROBE_CYCLES cycles.
REQ-027 Inputs SHALL be sampled only in IDLE.
- Changes to we, addr or wdata after grant are ignored.
- A req dropped after grant still completes and still pulses ack.
REQ-028 A requester wanting no further access SHALL deassert req on the clock edge that ends its ack cycle.
- A req still high in the following IDLE cycle starts a new access.
REQ-029 p_rdata SHALL hold its value until the next read completes on the same port; writes SHALL NOT alter it.
REQ-030 At most one ack SHALL be high in any cycle.

Reset
REQ-031 While rst is high, regardless of state, the block SHALL immediately force the following:
- state = IDLE, busy = 0;
- ram_r = ram_w = 0, both acks = 0;
- ram_addr = 0, ram_wdata = 0;
- both rdata registers = 0, strobe counter = 0, last_grant = 1.
REQ-032 A reset asserted mid-access SHALL abort that access with no ack.
- A request still high after rst falls SHALL be re-arbitrated from IDLE.

Verification
REQ-033 Port 0 write, addr 0x1234, data 0xA5 -> ram_w high for 2 cycles with ram_addr = 0x1234 and ram_wdata = 0xA5; p0_ack high 4 cycles after req is sampled.
REQ-034 Port 1 read, addr 0x1234, after REQ-033 -> ram_r high for 2 cycles; p1_rdata = 0xA5 when p1_ack pulses; p0_rdata unchanged.
REQ-035 Both req high continuously from reset -> grant order 0,1,0,1, one ack every 5 cycles, never both acks in one cycle.
REQ-036 Port 0 changes addr during STROBE -> ram_addr keeps the latched value; ack still pulses once.
REQ-037 rst pulsed during the second STROBE cycle -> strobes drop in the same cycle; no ack; all outputs reset; a held req is re-served starting 1 cycle after rst falls.
REQ-038 STROBE_CYCLES = 1 build -> ack at N+3; ram_r and ram_w are never high at the same time.
